// File: rtl/screen_pkg.sv
// Shared types and constants for the screen SRAM write port.
package screen_pkg;

  localparam int SCREEN_ADDR_W = 13;
  localparam int SCREEN_DATA_W = 16;
  localparam int ACTIVE_COLS   = 512;
  localparam int ACTIVE_ROWS   = 256;

  // Write cycle phases: address/data setup, write strobe, hold.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_t;

  // One buffered CPU screen write.
  typedef struct packed {
    logic [SCREEN_ADDR_W-1:0] addr;
    logic [SCREEN_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/screen_wr_fifo.sv
// Synchronous FIFO of screen write entries.
// merge=1 on a push rewrites the data of the newest entry instead of
// allocating a slot; tail_hit reports that the newest entry is still
// buffered (not leaving this cycle) and has the same address as push_entry.
module screen_wr_fifo
  import screen_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      merge,
  input  logic      pop,
  input  wr_entry_t push_entry,
  output wr_entry_t head,
  output logic      full,
  output logic      empty,
  output logic      tail_hit
);

  localparam int            PW         = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW:0]   count;
  logic          alloc;
  logic          tail_valid;
  wr_entry_t     mem [DEPTH];

  assign alloc    = push && !merge;
  assign tail_ptr = wr_ptr - PTR_ONE;
  assign head     = mem[rd_ptr];
  assign full     = (count == COUNT_FULL);
  assign empty    = (count == '0);

  // The newest entry is mergeable only if it is not the one leaving now.
  assign tail_valid = (count > COUNT_ONE) || ((count == COUNT_ONE) && !pop);
  assign tail_hit   = tail_valid && (mem[tail_ptr].addr == push_entry.addr);

  // Entry storage: allocate at the write pointer or rewrite the newest data.
  // NOTE: the storage array has no reset; count alone says which words are valid.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem[wr_ptr] <= push_entry;
    end else if (push) begin
      mem[tail_ptr].data <= push_entry.data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  // NOTE: registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      case ({alloc, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/screen_write_port.sv
// Write side of the shared 8K x 16 screen SRAM.
// CPU writes are buffered and replayed as 3-cycle SRAM write cycles that
// only start while the raster is in blanking; in IDLE the SRAM address pins
// follow the display read address.
// Optional: define SCREEN_WR_MERGE_EN to fold a push into the newest buffered
// entry when the addresses match.
module screen_write_port
  import screen_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int H_START_MAX = 796,
  parameter int V_TOTAL     = 525
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [SCREEN_ADDR_W-1:0] wr_addr,
  input  logic [SCREEN_DATA_W-1:0] wr_data,
  input  logic [9:0]               row,
  input  logic [9:0]               column,
  input  logic [SCREEN_ADDR_W-1:0] rd_addr,
  output logic [SCREEN_ADDR_W-1:0] sram_addr,
  output logic [SCREEN_DATA_W-1:0] sram_dq_out,
  output logic                     sram_dq_oe,
  output logic                     ce_n,
  output logic                     oe_n,
  output logic                     we_n,
  output logic                     ub_n,
  output logic                     lb_n,
  output logic                     busy
);

  localparam logic [9:0] COL_BLANK = 10'(ACTIVE_COLS);
  localparam logic [9:0] COL_LAST  = 10'(H_START_MAX);
  localparam logic [9:0] ROW_BLANK = 10'(ACTIVE_ROWS);
  localparam logic [9:0] ROW_LAST  = 10'(V_TOTAL - 2);

`ifdef SCREEN_WR_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  wr_state_t state;
  wr_state_t state_next;
  wr_entry_t wr_reg;
  wr_entry_t head;
  wr_entry_t push_entry;
  logic      push;
  logic      pop;
  logic      merge;
  logic      full;
  logic      empty;
  logic      tail_hit;
  logic      start_ok;

  // A write may start only if all three cycles fit inside blanking.
  assign start_ok = ((column >= COL_BLANK) && (column <= COL_LAST)) ||
                    ((row >= ROW_BLANK) && (row <= ROW_LAST));

  assign wr_ready   = !full;
  assign push       = wr_valid && !full;
  assign push_entry = '{addr: wr_addr, data: wr_data};
  assign merge      = MERGE_EN && tail_hit;

  screen_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .merge      (merge),
    .pop        (pop),
    .push_entry (push_entry),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .tail_hit   (tail_hit)
  );

  // Write-cycle state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: start from IDLE when an entry waits and the raster allows it.
  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && start_ok) begin
          pop        = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:   state_next = STROBE;
      STROBE:  state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write register: captures the FIFO head as a write cycle starts.
  always_ff @(posedge clk) begin
    if (!rst_n)   wr_reg <= '0;
    else if (pop) wr_reg <= head;
  end

  // SRAM strobes registered from the next state so the pins never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_n       <= 1'b1;
      oe_n       <= 1'b0;
      sram_dq_oe <= 1'b0;
    end else begin
      we_n       <= (state_next != STROBE);
      oe_n       <= (state_next != IDLE);
      sram_dq_oe <= (state_next != IDLE);
    end
  end

  assign sram_addr   = sram_dq_oe ? wr_reg.addr : rd_addr;
  assign sram_dq_out = wr_reg.data;
  assign busy        = !empty || (state != IDLE);
  assign ce_n        = 1'b0;
  assign ub_n        = 1'b0;
  assign lb_n        = 1'b0;

endmodule
